// File: rtl/vehicle_counter_if.sv
// Sensor, clear and count bundle between the lane sensors, the vehicle counter
// and the traffic light controller. The master side drives sensors and clears;
// the slave side (the counter) returns counts and sticky saturation flags.
interface vehicle_counter_if #(
    parameter int CNT_W = 4
);
    logic             sens_ns;
    logic             sens_sn;
    logic             sens_ew;
    logic             sens_we;
    logic             clr_ns;
    logic             clr_sn;
    logic             clr_ew;
    logic             clr_we;
    logic [CNT_W-1:0] count_ns_4b;
    logic [CNT_W-1:0] count_sn_4b;
    logic [CNT_W-1:0] count_ew_4b;
    logic [CNT_W-1:0] count_we_4b;
    logic [3:0]       ovf;

    modport master (
        output sens_ns, sens_sn, sens_ew, sens_we,
        output clr_ns, clr_sn, clr_ew, clr_we,
        input  count_ns_4b, count_sn_4b, count_ew_4b, count_we_4b, ovf
    );

    modport slave (
        input  sens_ns, sens_sn, sens_ew, sens_we,
        input  clr_ns, clr_sn, clr_ew, clr_we,
        output count_ns_4b, count_sn_4b, count_ew_4b, count_we_4b, ovf
    );
endinterface

// File: rtl/vehicle_counter.sv
// Per-approach vehicle tally: sync, debounce, rising-edge detect, saturating count.
// Latency: stable raw rise captured at edge k changes the count at edge k+DEB_CYCLES+3.
// Backpressure: none; clears are level-sensitive and always accepted.
module vehicle_counter #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic            clk,
    input  logic            rst,
    vehicle_counter_if.slave bus
);
    localparam int              TW     = $clog2(DEB_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT   = '1;

    // Lane order throughout: 0=NS, 1=SN, 2=EW, 3=WE (matches ovf bit order).
    logic [3:0]       sens;
    logic [3:0]       clr;
    logic [3:0]       s1;
    logic [3:0]       s;
    logic [3:0]       d;
    logic [3:0]       d_q;
    logic [3:0]       arr;
    logic [3:0]       ovf_r;
    logic [TW-1:0]    t   [4];
    logic [CNT_W-1:0] cnt [4];

    assign sens = {bus.sens_we, bus.sens_ew, bus.sens_sn, bus.sens_ns};
    assign clr  = {bus.clr_we, bus.clr_ew, bus.clr_sn, bus.clr_ns};

    // Two-flop synchroniser on the asynchronous raw sensors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= sens;
            s  <= s1;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
            for (int i = 0; i < 4; i++) t[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] != d[i]) begin
                    if (t[i] == T_LAST) begin
                        d[i] <= s[i];
                        t[i] <= '0;
                    end else begin
                        t[i] <= t[i] + 1'b1;
                    end
                end else begin
                    t[i] <= '0;
                end
            end
        end
    end

    // Registered rising-edge detect: one arrival pulse per accepted 0->1 transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            arr <= '0;
        end else begin
            d_q <= d;
            arr <= d & ~d_q;
        end
    end

    // Saturating counters; a clear coinciding with an arrival keeps that vehicle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (clr[i] && arr[i]) begin
                    cnt[i]   <= CNT_W'(1);
                    ovf_r[i] <= 1'b0;
                end else if (clr[i]) begin
                    cnt[i]   <= '0;
                    ovf_r[i] <= 1'b0;
                end else if (arr[i]) begin
                    if (cnt[i] == SAT) ovf_r[i] <= 1'b1;
                    else               cnt[i]   <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.count_ns_4b = cnt[0];
    assign bus.count_sn_4b = cnt[1];
    assign bus.count_ew_4b = cnt[2];
    assign bus.count_we_4b = cnt[3];
    assign bus.ovf         = ovf_r;
endmodule
